// File: rtl/ttl_fifo_pkg.sv
// ttl_fifo_pkg: shared count-width helper and empty-output constant for the register FIFO
package ttl_fifo_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  localparam logic EMPTY_Q = 1'b0;
endpackage

// File: rtl/ttl_fifo_ptr.sv
// ttl_fifo_ptr: wrap-around pointer register with synchronous reset and increment enable
module ttl_fifo_ptr #(
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  always_ff @(posedge clk)
    ptr <= rst ? '0 : ptr + AW'(inc);
endmodule

// File: rtl/ttl_fifo_reg.sv
// ttl_fifo_reg: first-word-fall-through register FIFO with three-state head output, flags and sticky errors
module ttl_fifo_reg
  import ttl_fifo_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = cnt_w(DEPTH)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             WE,
  input  logic             RE,
  input  logic             OE_n,
  output tri   [WIDTH-1:0] Q,
  output logic             EMPTY_n,
  output logic             FULL_n,
  output logic [CW-1:0]    COUNT,
  output logic             OVF,
  output logic             UNF
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             push, pop;
  assign EMPTY_n = COUNT != '0;
  assign FULL_n  = COUNT != CW'(DEPTH);
  assign pop     = RE && EMPTY_n;
  assign push    = WE && (FULL_n || RE);
  ttl_fifo_ptr #(.AW(AW)) u_wp (.clk(CK), .rst(RST), .inc(push), .ptr(wp));
  ttl_fifo_ptr #(.AW(AW)) u_rp (.clk(CK), .rst(RST), .inc(pop),  .ptr(rp));
  always_ff @(posedge CK)
    if (push && !RST) mem[wp] <= D;
  always_ff @(posedge CK) begin
    COUNT <= RST ? '0 : push && !pop ? COUNT + CW'(1) : pop && !push ? COUNT - CW'(1) : COUNT;
    OVF   <= !RST && (OVF || (WE && !FULL_n && !RE));
    UNF   <= !RST && (UNF || (RE && !EMPTY_n));
  end
  assign Q = OE_n ? {WIDTH{1'bz}} : EMPTY_n ? mem[rp] : {WIDTH{EMPTY_Q}};
endmodule
